serial_cla_add_ctrl: RTL and testbench
======================================

// Module: serial_cla_add_ctrl
// PURPOSE
//   Sequencer that time-shares one 4-bit carryLookahead slice to add wide operands.
//   It accepts a TOTAL_WIDTH operand pair over a valid/ready handshake.
//   It walks the operands LSB-first through the slice, one nibble per cycle, and registers the carry between cycles.
//   It presents the TOTAL_WIDTH+1 result on a held valid/ready output.
//   Sits between a request source and result consumer where area matters more than latency.
// PARAMETERS
//   TOTAL_WIDTH  16  operand width; must be a nonzero multiple of 4 (elaboration error otherwise)
//   (localparam) NUM_SLICES = TOTAL_WIDTH/4  cycles spent in RUN per operation
// PORTS
//   clock      in   1              single clock, all state on rising edge
//   reset_n    in   1              asynchronous, active-low reset
//   in_valid   in   1              operand pair valid
//   in_ready   out  1              block can accept an operand pair
//   in_a       in   TOTAL_WIDTH    operand A
//   in_b       in   TOTAL_WIDTH    operand B
//   in_sub     in   1              subtract select (present only with SERIAL_CLA_SUB_EN)
//   out_valid  out  1              result valid
//   out_ready  in   1              consumer accepts result
//   out_sum    out  TOTAL_WIDTH+1  result; MSB = final carry-out
//   busy       out  1              high in RUN or DONE
// BEHAVIOUR
//   Clock and reset: one clock domain; reset is asynchronous, active-low (reset_n).
//   Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0.
//     Operand shift regs, result reg, carry reg and slice counter are all cleared.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1.
//     On in_valid&&in_ready: capture in_a/in_b into shift regs, carry<=0, cnt<=0, go to RUN.
//     Operands need not be held after the accept edge.
//   RUN: in_ready=0.
//     Each cycle the slice adds a_reg[3:0] + b_reg[3:0] + carry.
//     The sum nibble shifts into the result reg from the top; a_reg/b_reg shift right by 4; carry<=cout; cnt++.
//     On cnt==NUM_SLICES-1: out_sum <= {cout, result}, go to DONE.
//   DONE: out_valid=1, in_ready=0; out_sum held stable.
//     On out_valid&&out_ready: go to IDLE; out_valid drops the next cycle.
//     out_sum keeps its last value until the next DONE.
//   Latency: out_valid rises exactly NUM_SLICES edges after the accept edge.
//     Minimum initiation interval is NUM_SLICES+2 cycles; there is no overlap of operations.
//   Width rule: out_sum = in_a + in_b (unsigned, TOTAL_WIDTH+1 bits, no truncation).
//   Boundary conditions:
//     in_valid while busy is ignored; no queuing.
//     out_ready high on DONE entry gives a one-cycle DONE.
//     out_ready while not in DONE is ignored.
//     reset_n low mid-operation aborts immediately: the result is discarded, no out_valid pulse, carry is cleared.
//     in_valid and out_ready may be high together; handshakes are evaluated per state only.
// CONFIGURATION
//   SERIAL_CLA_SUB_EN defined:
//     in_sub port exists and is sampled at accept.
//     When in_sub=1: b_reg <= ~in_b, initial carry <= 1.
//     out_sum = in_a - in_b as two's complement (TOTAL_WIDTH LSBs); MSB=1 means no borrow.
//   SERIAL_CLA_SUB_EN undefined: no in_sub port; add only; initial carry is always 0.
// TESTING (TOTAL_WIDTH=16)
//   1. Reset: assert reset_n=0 mid-cycle
//      -> immediately in_ready=1, out_valid=0, busy=0, out_sum=0.
//   2. 0x1234+0x4321, out_ready=1
//      -> out_sum=0x05555; out_valid high exactly 4 edges after accept, for 1 cycle.
//   3. 0xFFFF+0x0001 -> out_sum=0x10000 (carry ripples across all 4 slices).
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid
//      -> out_sum stable, in_ready=0, extra requests not accepted.
//   5. Accept 0xFFFF+0xFFFF, reset after 2 RUN cycles, then 0x0003+0x0004
//      -> no out_valid for the first op; second op gives 0x00007.
//   6. SERIAL_CLA_SUB_EN: 0x0005-0x0003 -> 0x10002; 0x0003-0x0005 -> 0x0FFFE.

Source files
------------

// File: rtl/serial_cla_add_ctrl_if.sv
// Operand/result handshake bundle for serial_cla_add_ctrl.
// in_sub exists only when SERIAL_CLA_SUB_EN is defined.
`timescale 1ns/1ps
interface serial_cla_add_ctrl_if #(
    parameter int TOTAL_WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [TOTAL_WIDTH-1:0] in_a;
    logic [TOTAL_WIDTH-1:0] in_b;
`ifdef SERIAL_CLA_SUB_EN
    logic                   in_sub;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [TOTAL_WIDTH:0]   out_sum;

    modport master (
        output in_valid, in_a, in_b, out_ready,
`ifdef SERIAL_CLA_SUB_EN
        output in_sub,
`endif
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
`ifdef SERIAL_CLA_SUB_EN
        input  in_sub,
`endif
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/serial_cla_add_ctrl.sv
// Serial wide adder: one 4-bit carry-lookahead slice reused LSB-first, one nibble per cycle.
// Optional subtract mode (in_sub) is enabled by defining SERIAL_CLA_SUB_EN.
`timescale 1ns/1ps
module serial_cla_add_ctrl #(
    parameter int TOTAL_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    serial_cla_add_ctrl_if.slave bus,
    output logic                 busy
);
    localparam int NUM_SLICES = TOTAL_WIDTH / 4;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    generate
        if ((TOTAL_WIDTH <= 0) || ((TOTAL_WIDTH % 4) != 0)) begin : g_bad_width
            $error("serial_cla_add_ctrl: TOTAL_WIDTH must be a nonzero multiple of 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TOTAL_WIDTH-1:0] r_a;
    logic [TOTAL_WIDTH-1:0] r_b;
    logic [TOTAL_WIDTH-1:0] r_result;
    logic [TOTAL_WIDTH:0]   r_sum;
    logic                   r_carry;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_sub;
    logic                   w_last;
    logic [3:0]             w_p;
    logic [3:0]             w_g;
    logic [3:0]             w_c;
    logic                   w_cout;
    logic [3:0]             w_slice_sum;
    logic [TOTAL_WIDTH+3:0] w_result_cat;
    logic [TOTAL_WIDTH-1:0] w_result_next;

`ifdef SERIAL_CLA_SUB_EN
    assign w_sub = bus.in_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Lookahead slice: every carry is a flat function of p/g and the registered carry-in.
    assign w_p = r_a[3:0] ^ r_b[3:0];
    assign w_g = r_a[3:0] & r_b[3:0];
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_slice_sum = w_p ^ w_c;

    // New nibble enters at the top so the LSB nibble ends up in bits [3:0] after the last slice.
    assign w_result_cat  = {w_slice_sum, r_result};
    assign w_result_next = w_result_cat[TOTAL_WIDTH+3:4];
    assign w_last        = (r_cnt == CNT_W'(NUM_SLICES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= w_sub ? ~bus.in_b : bus.in_b;
                        r_carry <= w_sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_result <= w_result_next;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum <= {w_cout, w_result_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_sum = r_sum;
endmodule

// File: tb/tb_serial_cla_add_ctrl.sv
// Self-checking bench for serial_cla_add_ctrl (TOTAL_WIDTH=16) against a transaction-level model.
// Define SERIAL_CLA_SUB_EN to also exercise subtract mode.
`timescale 1ns/1ps
module tb_serial_cla_add_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    bit   tb_sub;

    serial_cla_add_ctrl_if #(.TOTAL_WIDTH(W)) bus();

`ifdef SERIAL_CLA_SUB_EN
    assign bus.in_sub = tb_sub;
`endif

    serial_cla_add_ctrl #(.TOTAL_WIDTH(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result defined arithmetically: sum with carry-out, or difference with a no-borrow flag.
    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        logic [W-1:0] diff;
        if (sub) begin
            diff = a - b;
            return {(a >= b), diff};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Transaction model: idle -> N cycles of work -> result held until taken.
    bit         m_idle     = 1'b0;
    int         m_run_left = 0;
    bit         m_done     = 1'b0;
    logic [W:0] m_sum      = '0;
    logic [W:0] m_pending  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle     = 1'b1;
            m_run_left = 0;
            m_done     = 1'b0;
            m_sum      = '0;
        end else if (m_idle) begin
            if (bus.in_valid === 1'b1) begin
                m_pending  = ref_result(bus.in_a, bus.in_b, tb_sub);
                m_run_left = N;
                m_idle     = 1'b0;
            end
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) begin
                m_done = 1'b1;
                m_sum  = m_pending;
            end
        end else if (m_done && bus.out_ready === 1'b1) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("in_ready",  32'(bus.in_ready),  32'(m_idle));
            check("out_valid", 32'(bus.out_valid), 32'(m_done));
            check("busy",      32'(busy),          32'(!m_idle));
            check("out_sum",   32'(bus.out_sum),   32'(m_sum));
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(k < 30), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
        check({tag, "_out_sum"},   32'(bus.out_sum),   32'd0);
    endtask

    // One operation; stall=0 holds out_ready high from the accept, else out_ready stays low for stall DONE cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                          input int stall, output logic [W:0] got);
        int         edges;
        logic [W:0] held;
        wait_idle();
        bus.in_a      = a;
        bus.in_b      = b;
        tb_sub        = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        tb_sub       = bit'($urandom_range(0, 1));
        edges        = 0;
        while (bus.out_valid !== 1'b1 && edges < 20) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check("latency", 32'(edges), 32'(N));
        held = bus.out_sum;
        got  = held;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("hold_sum",   32'(bus.out_sum),   32'(held));
            check("hold_ready", 32'(bus.in_ready),  32'd0);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W:0]   got;
        logic [W-1:0] ra, rb;
        bit           rs;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        tb_sub        = 1'b0;

        // Reset asserted between clock edges must take effect at once.
        #23 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        cmp_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 0, got);
        check("add_1234_4321", 32'(got), 32'h05555);

        run_op(16'hFFFF, 16'h0001, 1'b0, 2, got);
        check("add_ffff_0001", 32'(got), 32'h10000);

        run_op(16'hA5A5, 16'h5A5A, 1'b0, 5, got);
        check("add_a5a5_5a5a", 32'(got), 32'h0FFFF);

        // Abort mid-operation, then confirm no stale result appears.
        wait_idle();
        bus.in_a     = 16'hFFFF;
        bus.in_b     = 16'hFFFF;
        tb_sub       = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h0003, 16'h0004, 1'b0, 1, got);
        check("add_after_abort", 32'(got), 32'h00007);

`ifdef SERIAL_CLA_SUB_EN
        run_op(16'h0005, 16'h0003, 1'b1, 0, got);
        check("sub_5_3", 32'(got), 32'h10002);
        run_op(16'h0003, 16'h0005, 1'b1, 0, got);
        check("sub_3_5", 32'(got), 32'h0FFFE);
`endif

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_CLA_SUB_EN
            rs = bit'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), got);
            check("rand_op", 32'(got), 32'(ref_result(ra, rb, rs)));
        end

        // Free-running traffic: valid and ready toggle independently, checked cycle by cycle.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
`ifdef SERIAL_CLA_SUB_EN
            tb_sub        = bit'($urandom_range(0, 1));
`endif
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
